// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller: BCD time registers, RUN/PAUSED/ADJUST sequencing and blink mask.
// Define STOPWATCH_SAT_EN to hold at MIN_MAX:59 in RUN instead of wrapping to 00:00.
module stopwatch_ctrl #(
  parameter int MIN_MAX = 99
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_blink,
  input  logic       pause_p,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] blink_mask,
  output logic       paused
);

  localparam logic [3:0] MAX_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_O = 4'(MIN_MAX % 10);

  typedef enum logic [1:0] {RUN, PAUSED, ADJUST} state_t;

  state_t     state_q, state_d;
  logic       resume_q, resume_d;
  logic       phase_q, phase_d;
  logic [7:0] sec_q, sec_d;   // {tens, ones}
  logic [7:0] min_q, min_d;   // {tens, ones}
  logic [3:0] blink_mask_q, blink_mask_d;
  logic       paused_q, paused_d;
  logic       at_max;

  function automatic logic [7:0] inc_sec(input logic [7:0] s);
    if (s[3:0] == 4'd9) begin
      if (s[7:4] == 4'd5) return 8'h00;
      return {s[7:4] + 4'd1, 4'd0};
    end
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_min(input logic [7:0] m);
    if (m == {MAX_T, MAX_O}) return 8'h00;
    if (m[3:0] == 4'd9) return {m[7:4] + 4'd1, 4'd0};
    return {m[7:4], m[3:0] + 4'd1};
  endfunction

  assign at_max = (sec_q == 8'h59) && (min_q == {MAX_T, MAX_O});

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      resume_q     <= 1'b0;
      phase_q      <= 1'b0;
      sec_q        <= 8'h00;
      min_q        <= 8'h00;
      blink_mask_q <= 4'b0000;
      paused_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      resume_q     <= resume_d;
      phase_q      <= phase_d;
      sec_q        <= sec_d;
      min_q        <= min_d;
      blink_mask_q <= blink_mask_d;
      paused_q     <= paused_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    phase_d  = phase_q ^ tick_blink;
    sec_d    = sec_q;
    min_d    = min_q;

    case (state_q)
      RUN: begin
        // adj takes priority over a coincident pause_p or tick_1hz
        if (adj) begin
          state_d  = ADJUST;
          resume_d = 1'b0;
        end else begin
          if (tick_1hz) begin
`ifdef STOPWATCH_SAT_EN
            if (!at_max) begin
              sec_d = inc_sec(sec_q);
              if (sec_q == 8'h59) min_d = inc_min(min_q);
            end
`else
            if (at_max) begin
              sec_d = 8'h00;
              min_d = 8'h00;
            end else begin
              sec_d = inc_sec(sec_q);
              if (sec_q == 8'h59) min_d = inc_min(min_q);
            end
`endif
          end
          if (pause_p) state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (adj) begin
          state_d  = ADJUST;
          resume_d = 1'b1;
        end else if (pause_p) begin
          state_d = RUN;
        end
      end
      ADJUST: begin
        if (!adj) begin
          state_d = resume_q ? PAUSED : RUN;
        end else begin
          if (pause_p) resume_d = ~resume_q;
          if (tick_2hz) begin
            if (sel) sec_d = inc_sec(sec_q);
            else     min_d = inc_min(min_q);
          end
        end
      end
      default: state_d = RUN;
    endcase

    // Outputs are registered from next-state so they follow the sampling edge
    blink_mask_d = 4'b0000;
    if (state_d == ADJUST && phase_d) blink_mask_d = sel ? 4'b0011 : 4'b1100;
    paused_d = (state_d == PAUSED) || (state_d == ADJUST && resume_d);
  end

  assign min_tens   = min_q[7:4];
  assign min_ones   = min_q[3:0];
  assign sec_tens   = sec_q[7:4];
  assign sec_ones   = sec_q[3:0];
  assign blink_mask = blink_mask_q;
  assign paused     = paused_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Controller that sequences the tick enables from the clock divider into a 4-digit MM:SS stopwatch. It owns the BCD time registers and the run/pause/adjust state machine. It drives the digit values and a per-digit blank mask to the seven-segment display driver, which scans using the 500 Hz tick. Button inputs arrive already debounced from the input conditioning block.

## Interface

Parameters:
- `MIN_MAX`, default 99: highest minute value, decimal, legal range 1..99; the minutes field wraps or saturates here.

Ports:
- `clk_100mhz`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `tick_1hz`  in  1  one-cycle pulse, 1 Hz; advances run time.
- `tick_2hz`  in  1  one-cycle pulse, 2 Hz; advances the adjusted field.
- `tick_blink`  in  1  one-cycle pulse, 4 Hz; toggles blink phase.
- `pause_p`  in  1  one-cycle pulse, debounced press; toggles pause.
- `adj`  in  1  level; 1 = adjust mode.
- `sel`  in  1  level; 0 = adjust minutes, 1 = adjust seconds.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD digits, registered.
- `blink_mask`  out  4  1 = blank digit; bit3 = `min_tens` … bit0 = `sec_ones`; registered.
- `paused`  out  1  1 when state is PAUSED, or ADJUST with a PAUSED resume target.

## Operation

- State register, 3 states: RUN, PAUSED, ADJUST. A 1-bit `resume` register holds the target on exit from ADJUST (0 = RUN, 1 = PAUSED).
- RUN:
  - `adj`=1 → ADJUST, `resume`=0.
  - Otherwise `pause_p` → PAUSED.
- PAUSED:
  - `adj`=1 → ADJUST, `resume`=1.
  - Otherwise `pause_p` → RUN.
- ADJUST:
  - `adj`=0 → RUN if `resume`=0, else PAUSED.
  - `pause_p` toggles `resume` only.
- Counting in RUN: on `tick_1hz` with `adj`=0, seconds increment.
  - `sec_ones` 9→0 carries into `sec_tens`.
  - `sec_tens` 5→0 carries into minutes.
  - Minutes at `MIN_MAX` with seconds 59 is overflow; see Configuration.
- Adjust in ADJUST: on `tick_2hz` the selected field increments.
  - Seconds: 00..59, wraps to 00, no carry into minutes.
  - Minutes: 00..`MIN_MAX`, wraps to 00.
  - `sel` is sampled every cycle, so changing it mid-adjust redirects the next increment.
- Blink: a `phase` bit toggles on every `tick_blink` in all states.
  - ADJUST: `blink_mask` = `phase` ? (`sel` ? 4'b0011 : 4'b1100) : 4'b0000.
  - All other states: `blink_mask` = 4'b0000.
- Digits are always held as legal BCD. No field ever holds a value above 9, or `sec_tens` above 5.

## Timing

- Reset, asynchronous:
  - State RUN, `resume`=0, `phase`=0.
  - All digits 0, `blink_mask`=0, `paused`=0.
  - Counting resumes on the first `tick_1hz` after `rst` deasserts.
- All outputs are registered. Digits and `blink_mask` update on the clock edge that samples the tick, so latency is 1 cycle.
- The cycle in which `adj` first samples high:
  - A coincident `tick_1hz` is ignored, because counting is qualified by `adj`=0.
  - A coincident `tick_2hz` is ignored, because the state is not yet ADJUST.
- The cycle in which `adj` samples low (exit from ADJUST): a coincident `tick_1hz` is ignored; counting restarts on the next tick.
- `pause_p` coincident with `tick_1hz` in RUN: the tick is counted and the state becomes PAUSED. In PAUSED, `tick_1hz` is ignored.
- `pause_p` and `adj` rising in the same cycle: adjust wins, and `resume` records the pre-toggle state, i.e. the `pause_p` is dropped.
- Reset asserted mid-adjust or mid-carry: all state clears immediately; no partial carry survives.
- Back-to-back `pause_p` pulses on consecutive cycles: each one toggles.

## Configuration

- `STOPWATCH_SAT_EN` undefined (default): at `MIN_MAX`:59 in RUN, the next `tick_1hz` wraps time to 00:00 and counting continues.
- `STOPWATCH_SAT_EN` defined: at `MIN_MAX`:59 in RUN, the time holds at `MIN_MAX`:59.
  - Further `tick_1hz` pulses are ignored; the state stays RUN.
  - Adjust-mode wrap behaviour is unchanged.

## Test plan

- Reset, then 61 `tick_1hz` pulses → digits read 01:01, `paused`=0, `blink_mask`=0.
- Preload to 99:59 via adjust, exit, then one `tick_1hz` → 00:00 by default; holds 99:59 with `STOPWATCH_SAT_EN`.
- `pause_p`, then 5 `tick_1hz` → time unchanged and `paused`=1; a second `pause_p` plus 1 tick → time +1 s.
- `adj`=1, `sel`=1 at 00:58, then 3 `tick_2hz` → 00:01 with minutes unchanged; `blink_mask` alternates 0011/0000 on each `tick_blink`.
- `adj`=1, `sel`=0, then 100 `tick_2hz` → minutes wrap 99→00 with seconds untouched; `blink_mask` alternates 1100/0000.
- Assert `rst` while in ADJUST at 12:34 with `phase`=1 → all outputs 0 immediately; after release, state RUN and 1 tick gives 00:01.
